// File: rtl/seq_div_pkg.sv
// Shared types for the seq_div iterative divider: FSM state encoding.
package seq_div_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE,
        DIV,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/seq_div_addsub.sv
// Combinational add/subtract cell shared by the divide steps and the final remainder correction.
module seq_div_addsub #(
    parameter int N = 6
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] s
);

    assign s = sub ? (a - b) : (a + b);

endmodule

// File: rtl/seq_div.sv
// Iterative non-restoring divider behind a start/done handshake.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands (truncating division with overflow flag).
module seq_div
    import seq_div_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dz,
    output logic             v
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   p;
    logic [WIDTH:0]   d;
    logic [WIDTH-1:0] q;
    logic             dz_cap;
    logic [WIDTH:0]   as_a;
    logic [WIDTH:0]   as_s;
    logic             as_sub;
    logic [WIDTH-1:0] r_mag;

`ifdef SEQ_DIV_SIGNED_EN
    logic sign_q;
    logic sign_r;
    logic ovf;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction
`else
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x;
    endfunction
`endif

    // DIV feeds the shifted remainder and picks subtract/add from the old sign; FIX only ever adds D back.
    assign as_a   = (state == FIX) ? p : {p[WIDTH-1:0], q[WIDTH-1]};
    assign as_sub = (state == DIV) && !p[WIDTH];
    assign r_mag  = p[WIDTH] ? as_s[WIDTH-1:0] : p[WIDTH-1:0];

    seq_div_addsub #(.N(WIDTH + 1)) u_addsub (
        .a   (as_a),
        .b   (d),
        .sub (as_sub),
        .s   (as_s)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        case (state)
            IDLE:    if (start) state_next = DIV;
            DIV:     if (count == CW'(WIDTH - 1)) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            p         <= '0;
            d         <= '0;
            q         <= '0;
            dz_cap    <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dz        <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            ovf       <= 1'b0;
            v         <= 1'b0;
`endif
        end else begin
            done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        count  <= '0;
                        p      <= '0;
                        q      <= mag(dividend);
                        d      <= {1'b0, mag(divisor)};
                        dz_cap <= (divisor == '0);
`ifdef SEQ_DIV_SIGNED_EN
                        sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        sign_r <= dividend[WIDTH-1];
                        ovf    <= (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
`endif
                    end
                end
                DIV: begin
                    p     <= as_s;
                    q     <= {q[WIDTH-2:0], ~as_s[WIDTH]};
                    count <= count + CW'(1);
                end
                FIX: begin
`ifdef SEQ_DIV_SIGNED_EN
                    q <= sign_q ? -q : q;
                    p <= {1'b0, (sign_r ? -r_mag : r_mag)};
`else
                    p <= {1'b0, r_mag};
`endif
                end
                DONE: begin
                    quotient  <= q;
                    remainder <= p[WIDTH-1:0];
                    dz        <= dz_cap;
`ifdef SEQ_DIV_SIGNED_EN
                    v         <= ovf;
`endif
                end
                default: ;
            endcase
        end
    end

`ifndef SEQ_DIV_SIGNED_EN
    assign v = 1'b0;
`endif

endmodule

// File: tb/tb_seq_div.sv
// Scoreboard bench for seq_div: driver pushes reference results, a monitor checks them on done.
module tb_seq_div;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         dz;
    logic         v;

    seq_div #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dz        (dz),
        .v         (v)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         v;
        int           done_cyc;
    } exp_t;

    exp_t         scoreboard[$];
    exp_t         mon_e;
    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    logic [W-1:0] hold_q = '0;
    logic [W-1:0] hold_r = '0;
    logic         hold_dz = 1'b0;
    logic         hold_v = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: plain integer division with the divide-by-zero and overflow rules.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   na, nb, qi, ri;
        e.dz = (b == '0);
        e.v = 1'b0;
        e.done_cyc = 0;
`ifdef SEQ_DIV_SIGNED_EN
        na = $signed(a);
        nb = $signed(b);
        if (nb == 0) begin
            qi = (na >= 0) ? -1 : 1;
            ri = na;
        end else if (na == -(1 << (W - 1)) && nb == -1) begin
            qi = na;
            ri = 0;
            e.v = 1'b1;
        end else begin
            qi = na / nb;
            ri = na % nb;
        end
`else
        na = int'(a);
        nb = int'(b);
        if (nb == 0) begin
            qi = (1 << W) - 1;
            ri = na;
        end else begin
            qi = na / nb;
            ri = na % nb;
        end
`endif
        e.q = qi[W-1:0];
        e.r = ri[W-1:0];
        return e;
    endfunction

    task automatic push_expected(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e = model(a, b);
        e.done_cyc = cyc + 1 + W + 2;
        scoreboard.push_back(e);
    endtask

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
        int waited = 0;
        @(negedge clk);
        start = 1'b1;
        dividend = a;
        divisor = b;
        while (busy && waited < 2 * (W + 3)) begin
            @(negedge clk);
            waited++;
        end
        if (busy) begin
            check("accept_timeout", busy, 0);
            start = 1'b0;
            return;
        end
        push_expected(a, b);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (scoreboard.size() != 0 && n < 4 * (W + 3)) begin
            @(negedge clk);
            n++;
        end
        if (scoreboard.size() != 0) begin
            check("drain_timeout", scoreboard.size(), 0);
            scoreboard.delete();
        end
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input int eq, input int er, input int edz, input int ev);
        check({name, "_quotient"}, quotient, eq);
        check({name, "_remainder"}, remainder, er);
        check({name, "_dz"}, dz, edz);
        check({name, "_v"}, v, ev);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("busy_done_overlap", busy & done, 0);
            if (done) begin
                if (scoreboard.size() == 0) begin
                    check("unexpected_done", done, 0);
                end else begin
                    mon_e = scoreboard.pop_front();
                    check("sb_quotient", quotient, mon_e.q);
                    check("sb_remainder", remainder, mon_e.r);
                    check("sb_dz", dz, mon_e.dz);
                    check("sb_v", v, mon_e.v);
                    check("sb_latency", cyc, mon_e.done_cyc);
                    hold_q = mon_e.q;
                    hold_r = mon_e.r;
                    hold_dz = mon_e.dz;
                    hold_v = mon_e.v;
                end
            end else begin
                if (scoreboard.size() != 0 && cyc > scoreboard[0].done_cyc) begin
                    check("done_timeout", done, 1);
                    void'(scoreboard.pop_front());
                end
                check("hold_quotient", quotient, hold_q);
                check("hold_remainder", remainder, hold_r);
                check("hold_dz", dz, hold_dz);
                check("hold_v", v, hold_v);
            end
        end
    end

    initial begin
        int acc;
        int seen;

        repeat (3) @(negedge clk);
        checkOutput("reset", 0, 0, 0, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        rst = 1'b0;

        applyStimulus(5'd27, 5'd5);
        wait_idle();
`ifdef SEQ_DIV_SIGNED_EN
        checkOutput("div_27_5", 31, 0, 0, 0);
`else
        checkOutput("div_27_5", 5, 2, 0, 0);
`endif
        applyStimulus(5'd31, 5'd0);
        wait_idle();
`ifdef SEQ_DIV_SIGNED_EN
        checkOutput("div_31_0", 1, 31, 1, 0);
`else
        checkOutput("div_31_0", 31, 31, 1, 0);
`endif
        applyStimulus(5'd19, 5'd3);
        wait_idle();
`ifdef SEQ_DIV_SIGNED_EN
        checkOutput("div_m13_3", 28, 31, 0, 0);
`else
        checkOutput("div_19_3", 6, 1, 0, 0);
`endif
        applyStimulus(5'd16, 5'd31);
        wait_idle();
`ifdef SEQ_DIV_SIGNED_EN
        checkOutput("div_m16_m1", 16, 0, 0, 1);
`else
        checkOutput("div_16_31", 0, 16, 0, 0);
`endif

        acc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = 1'b1;
            dividend = W'($urandom_range(0, (1 << W) - 1));
            divisor = W'($urandom_range(0, (1 << W) - 1));
            if (!busy) begin
                push_expected(dividend, divisor);
                acc++;
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("burst_accepts", acc, 3);
        wait_idle();

        applyStimulus(5'd13, 5'd3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("reset_mid_div", 0, 0, 0, 0);
        check("reset_mid_div_busy", busy, 0);
        check("reset_mid_div_done", done, 0);
        scoreboard.delete();
        hold_q = '0;
        hold_r = '0;
        hold_dz = 1'b0;
        hold_v = 1'b0;
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("no_done_after_reset", seen, 0);
        applyStimulus(5'd13, 5'd3);
        wait_idle();
        checkOutput("div_13_3", 4, 1, 0, 0);

        repeat (150) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            applyStimulus(W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)));
        end
        wait_idle();

        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                applyStimulus(W'(a), W'(b));
            end
        end
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
